// File: rtl/dm_sba_engine.sv
// System-bus-access engine: runs sbcs/sbaddress/sbdata accesses on a req/gnt/rvalid bus.
// Ports: debugger CSR side (sb*_i / sb*_o), bus side (req/add/we/wdata/be/size, gnt/rvalid/rdata/err); SBA_TIMEOUT_EN adds a response timeout.
module dm_sba_engine #(
  parameter int BusWidth      = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   sbaddress_i,
  input  logic                   sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]    sbdata_i,
  input  logic                   sbdata_write_valid_i,
  input  logic                   sbdata_read_valid_i,
  input  logic [2:0]             sbaccess_i,
  input  logic                   sbreadonaddr_i,
  input  logic                   sbreadondata_i,
  input  logic                   sbautoincrement_i,
  output logic [AddrWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]    sbdata_o,
  output logic                   sbdata_valid_o,
  output logic                   sbbusy_o,
  output logic                   sbbusyerror_o,
  output logic [2:0]             sberror_o,
  output logic                   sberror_valid_o,
  output logic                   req_o,
  output logic [AddrWidth-1:0]   add_o,
  output logic                   we_o,
  output logic [BusWidth-1:0]    wdata_o,
  output logic [BusWidth/8-1:0]  be_o,
  output logic [2:0]             size_o,
  input  logic                   gnt_i,
  input  logic                   rvalid_i,
  input  logic [BusWidth-1:0]    rdata_i,
  input  logic                   err_i
);

  localparam int NB   = BusWidth / 8;
  localparam int OffW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, WAIT_READ, WAIT_WRITE
  } state_e;

  state_e state;

  logic [AddrWidth-1:0] addr_new;
  logic                 do_write;
  logic                 do_read;
  logic                 trig;
  logic                 size_err;
  logic                 align_err;
  logic [AddrWidth-1:0] align_mask;
  logic [NB-1:0]        be_new;
  logic [BusWidth-1:0]  wdata_new;
  logic [BusWidth-1:0]  rdata_sh;
  logic [BusWidth-1:0]  rdata_al;
  logic                 busy_req;

  // A data write wins over any read trigger and uses the freshly written address.
  assign addr_new = sbaddress_write_valid_i ? sbaddress_i : sbaddress_o;
  assign do_write = sbdata_write_valid_i;
  assign do_read  = !sbdata_write_valid_i &&
                    ((sbaddress_write_valid_i && sbreadonaddr_i) ||
                     (sbdata_read_valid_i && sbreadondata_i));
  assign trig     = do_write || do_read;

  assign size_err   = int'(sbaccess_i) > OffW;
  assign align_mask = (AddrWidth'(1) << sbaccess_i) - AddrWidth'(1);
  assign align_err  = |(addr_new & align_mask);

  assign busy_req = sbaddress_write_valid_i || sbdata_write_valid_i ||
                    (sbdata_read_valid_i && sbreadondata_i);

  assign sbbusy_o = (state != IDLE);

  always_comb begin
    int off;
    int nbytes;
    be_new    = '0;
    wdata_new = '0;
    off       = int'(addr_new[OffW-1:0]);
    nbytes    = 1 << sbaccess_i;
    for (int i = 0; i < NB; i++) begin
      be_new[i]          = (i >= off) && (i < off + nbytes);
      wdata_new[i*8 +: 8] = sbdata_i[(i % nbytes)*8 +: 8];
    end
  end

  // Read data is shifted down from its lane and trimmed to the access size.
  always_comb begin
    int nb_q;
    rdata_al = '0;
    nb_q     = 1 << size_o;
    rdata_sh = rdata_i >> {sbaddress_o[OffW-1:0], 3'b000};
    for (int i = 0; i < NB; i++) begin
      rdata_al[i*8 +: 8] = (i < nb_q) ? rdata_sh[i*8 +: 8] : 8'h00;
    end
  end

`ifdef SBA_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      sbaddress_o     <= '0;
      sbdata_o        <= '0;
      sbdata_valid_o  <= 1'b0;
      sbbusyerror_o   <= 1'b0;
      sberror_o       <= 3'd0;
      sberror_valid_o <= 1'b0;
      req_o           <= 1'b0;
      add_o           <= '0;
      we_o            <= 1'b0;
      wdata_o         <= '0;
      be_o            <= '0;
      size_o          <= 3'd0;
`ifdef SBA_TIMEOUT_EN
      tcnt            <= '0;
`endif
    end else begin
      sbdata_valid_o  <= 1'b0;
      sbbusyerror_o   <= 1'b0;
      sberror_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sbaddress_write_valid_i) sbaddress_o <= sbaddress_i;
          if (trig) begin
            if (size_err) begin
              sberror_o       <= 3'd4;
              sberror_valid_o <= 1'b1;
            end else if (align_err) begin
              sberror_o       <= 3'd3;
              sberror_valid_o <= 1'b1;
            end else begin
              req_o   <= 1'b1;
              we_o    <= do_write;
              add_o   <= addr_new & ({AddrWidth{1'b1}} << OffW);
              be_o    <= be_new;
              wdata_o <= wdata_new;
              size_o  <= sbaccess_i;
              state   <= do_write ? WRITE : READ;
            end
          end
        end
        READ, WRITE: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            state <= (state == READ) ? WAIT_READ : WAIT_WRITE;
`ifdef SBA_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        WAIT_READ, WAIT_WRITE: begin
          if (rvalid_i) begin
            state <= IDLE;
            if (err_i) begin
              sberror_o       <= 3'd2;
              sberror_valid_o <= 1'b1;
            end else begin
              if (state == WAIT_READ) begin
                sbdata_o       <= rdata_al;
                sbdata_valid_o <= 1'b1;
              end
              if (sbautoincrement_i)
                sbaddress_o <= sbaddress_o + (AddrWidth'(1) << size_o);
            end
          end
`ifdef SBA_TIMEOUT_EN
          else if (tcnt == TW'(TimeoutCycles - 1)) begin
            state           <= IDLE;
            sberror_o       <= 3'd1;
            sberror_valid_o <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
      if (state != IDLE && busy_req) sbbusyerror_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_sba_engine.sv
// Self-checking bench for dm_sba_engine with a 64-bit bus.
// Directed plan cases followed by randomized accesses against a transaction-level model.
module tb_dm_sba_engine;

  localparam int BW = 64;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] sbaddress_i;
  logic          sbaddress_write_valid;
  logic [BW-1:0] sbdata_i;
  logic          sbdata_write_valid;
  logic          sbdata_read_valid;
  logic [2:0]    sbaccess;
  logic          sbreadonaddr;
  logic          sbreadondata;
  logic          sbautoincrement;
  logic [AW-1:0] sbaddress;
  logic [BW-1:0] sbdata;
  logic          sbdata_valid;
  logic          sbbusy;
  logic          sbbusyerror;
  logic [2:0]    sberror;
  logic          sberror_valid;
  logic          req;
  logic [AW-1:0] add;
  logic          we;
  logic [BW-1:0] wdata;
  logic [7:0]    be;
  logic [2:0]    size;
  logic          gnt;
  logic          rvalid;
  logic [BW-1:0] rdata;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_data;

  dm_sba_engine #(.BusWidth(BW), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .sbaddress_i(sbaddress_i), .sbaddress_write_valid_i(sbaddress_write_valid),
    .sbdata_i(sbdata_i), .sbdata_write_valid_i(sbdata_write_valid),
    .sbdata_read_valid_i(sbdata_read_valid), .sbaccess_i(sbaccess),
    .sbreadonaddr_i(sbreadonaddr), .sbreadondata_i(sbreadondata),
    .sbautoincrement_i(sbautoincrement),
    .sbaddress_o(sbaddress), .sbdata_o(sbdata), .sbdata_valid_o(sbdata_valid),
    .sbbusy_o(sbbusy), .sbbusyerror_o(sbbusyerror),
    .sberror_o(sberror), .sberror_valid_o(sberror_valid),
    .req_o(req), .add_o(add), .we_o(we), .wdata_o(wdata), .be_o(be),
    .size_o(size), .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    sbaddress_write_valid = 1'b0;
    sbdata_write_valid    = 1'b0;
    sbdata_read_valid     = 1'b0;
    sbreadonaddr          = 1'b0;
    sbreadondata          = 1'b0;
  endtask

  function automatic logic [63:0] lane_mask(input int nbytes);
    return (nbytes >= 8) ? '1 : ((64'd1 << (nbytes * 8)) - 64'd1);
  endfunction

  // One debugger-initiated access with the testbench acting as the bus.
  // rod=1 triggers a read via sbdata read at the current address.
  task automatic access(input bit wr, input bit rod, input logic [AW-1:0] a,
                        input logic [2:0] acc, input logic [63:0] d,
                        input bit autoinc, input bit berr, input int gdly,
                        input int rdly, input logic [63:0] rd,
                        input bit poke);
    int nbytes, off, ecode;
    logic [7:0]  be_e;
    logic [63:0] wd_e, unit;
    nbytes = 1 << acc;
    sbaccess = acc;
    sbautoincrement = autoinc;
    if (rod) begin
      a = m_addr;
      sbdata_read_valid = 1'b1;
      sbreadondata = 1'b1;
    end else begin
      sbaddress_i = a;
      sbaddress_write_valid = 1'b1;
      sbreadonaddr = !wr;
    end
    if (wr) begin
      sbdata_i = d;
      sbdata_write_valid = 1'b1;
    end
    m_addr = a;
    tick();
    clear_in();
    ecode = (nbytes * 8 > BW) ? 4 : ((a % nbytes) != 0) ? 3 : 0;
    if (ecode != 0) begin
      chk("pre_err_valid", 64'(sberror_valid), 64'd1);
      chk("pre_err_code", 64'(sberror), 64'(ecode));
      chk("pre_err_noreq", 64'(req), 64'd0);
      chk("pre_err_addr", 64'(sbaddress), 64'(m_addr));
      tick();
      chk("pre_err_idle", 64'(sbbusy), 64'd0);
      return;
    end
    off  = int'(a % 8);
    be_e = 8'(((64'd1 << nbytes) - 64'd1) << off);
    unit = d & lane_mask(nbytes);
    wd_e = '0;
    for (int k = 0; k < 8 / nbytes; k++) wd_e |= unit << (k * nbytes * 8);
    chk("req_up", 64'(req), 64'd1);
    chk("busy_up", 64'(sbbusy), 64'd1);
    chk("we", 64'(we), 64'(wr));
    chk("add", 64'(add), 64'(a & ~32'h7));
    chk("be", 64'(be), 64'(be_e));
    chk("size", 64'(size), 64'(acc));
    if (wr) chk("wdata", wdata, wd_e);
    for (int i = 0; i < gdly; i++) tick();
    chk("req_hold", 64'(req), 64'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("req_drop", 64'(req), 64'd0);
    chk("busy_wait", 64'(sbbusy), 64'd1);
    if (poke) begin
      sbdata_i = 64'h1122;
      sbdata_write_valid = 1'b1;
      tick();
      clear_in();
      chk("busyerr_pulse", 64'(sbbusyerror), 64'd1);
      chk("busyerr_noreq", 64'(req), 64'd0);
      chk("busyerr_addr", 64'(sbaddress), 64'(m_addr));
    end
    for (int i = 0; i < rdly; i++) tick();
    chk("wait_noreq", 64'(req), 64'd0);
    rvalid = 1'b1;
    rdata  = rd;
    err    = berr;
    tick();
    rvalid = 1'b0;
    err    = 1'b0;
    if (berr) begin
      chk("bus_err_valid", 64'(sberror_valid), 64'd1);
      chk("bus_err_code", 64'(sberror), 64'd2);
    end else begin
      if (!wr) m_data = (rd >> (off * 8)) & lane_mask(nbytes);
      if (autoinc) m_addr = m_addr + AW'(nbytes);
    end
    chk("data_valid", 64'(sbdata_valid), 64'(!wr && !berr));
    chk("sbdata", sbdata, m_data);
    chk("sbaddress", 64'(sbaddress), 64'(m_addr));
    chk("busy_done", 64'(sbbusy), 64'd0);
    tick();
    chk("pulse_clear", 64'({sbdata_valid, sberror_valid, sbbusyerror}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    sbaddress_i = '0; sbdata_i = '0; sbaccess = 3'd0; sbautoincrement = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
    m_addr = '0; m_data = '0;
    tick(); tick();
    chk("rst_addr", 64'(sbaddress), 64'd0);
    chk("rst_data", sbdata, 64'd0);
    chk("rst_busy", 64'(sbbusy), 64'd0);
    chk("rst_bus", {req, we, be, size, add}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_pulses", 64'({sbdata_valid, sberror_valid, sbbusyerror}), 64'd0);
    rst = 1'b0;
    tick();

    // Read 0x1000, word, grant after 2 cycles.
    access(0, 0, 32'h1000, 3'd2, 0, 0, 0, 2, 1,
           64'h12345678_DEADBEEF, 0);
    // Byte write at 0x1003 with autoincrement.
    access(1, 0, 32'h1003, 3'd0, 64'hA5, 1, 0, 0, 1, 0, 0);
    // Misaligned word and oversized access.
    access(0, 0, 32'h1002, 3'd2, 0, 0, 0, 0, 0, 0, 0);
    access(0, 0, 32'h1000, 3'd4, 0, 0, 0, 0, 0, 0, 0);
    // Second sbdata write during WaitWrite.
    access(1, 0, 32'h2000, 3'd3, 64'hCAFEF00D_01234567, 0, 0, 1, 2, 0, 1);
    // Read with bus error leaves data and address alone.
    access(0, 0, 32'h3004, 3'd2, 0, 1, 1, 0, 1, 64'hFFFF_0000_1111_2222, 0);
    // Halfword read at upper lane, autoincrement wraps address.
    access(0, 0, 32'hFFFF_FFFE, 3'd1, 0, 1, 0, 1, 0,
           64'hBEEF_0000_0000_0000, 0);
    // Read triggered by sbdata read at the wrapped address.
    access(0, 1, 0, 3'd2, 0, 0, 0, 0, 0, 64'h0000_0000_8765_4321, 0);

    // Address write without readonaddr loads only.
    sbaddress_i = 32'h4444; sbaddress_write_valid = 1'b1;
    tick();
    clear_in();
    m_addr = 32'h4444;
    chk("addr_only_load", 64'(sbaddress), 64'h4444);
    chk("addr_only_noreq", 64'(req), 64'd0);

    // Reset during WaitRead; a late response is ignored.
    sbaddress_i = 32'h5000; sbaddress_write_valid = 1'b1;
    sbreadonaddr = 1'b1; sbaccess = 3'd2;
    tick();
    clear_in();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_addr = '0; m_data = '0;
    chk("midrst_busy", 64'(sbbusy), 64'd0);
    chk("midrst_req", 64'(req), 64'd0);
    rvalid = 1'b1; rdata = 64'h77;
    tick();
    rvalid = 1'b0;
    chk("late_rvalid", 64'(sbdata_valid), 64'd0);
    chk("late_data", sbdata, 64'd0);
    tick();

`ifdef SBA_TIMEOUT_EN
    begin
      int n;
      sbaddress_i = 32'h6000; sbaddress_write_valid = 1'b1;
      sbreadonaddr = 1'b1; sbaccess = 3'd2;
      tick();
      clear_in();
      m_addr = 32'h6000;
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      n = 0;
      while (!sberror_valid && n < 40) begin
        tick();
        n++;
      end
      chk("timeout_cycles", 64'(n), 64'(TO));
      chk("timeout_code", 64'(sberror), 64'd1);
      chk("timeout_idle", 64'(sbbusy), 64'd0);
      rvalid = 1'b1; rdata = 64'h99;
      tick();
      rvalid = 1'b0;
      chk("stray_rvalid", 64'(sbdata_valid), 64'd0);
      chk("timeout_addr", 64'(sbaddress), 64'(m_addr));
      tick();
    end
`endif

    // Randomized accesses; mostly aligned, occasionally misaligned or oversized.
    for (int t = 0; t < 60; t++) begin
      logic [2:0]    acc;
      logic [AW-1:0] a;
      int            nb;
      acc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                        : 3'($urandom_range(0, 3));
      nb  = 1 << acc;
      a   = AW'($urandom);
      if ($urandom_range(0, 5) != 0 && nb <= 8) a = a & ~AW'(nb - 1);
      access($urandom_range(0, 1), $urandom_range(0, 4) == 0, a, acc,
             {$urandom, $urandom}, $urandom_range(0, 1),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3),
             $urandom_range(0, 4), {$urandom, $urandom},
             $urandom_range(0, 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
